// File: rtl/fir_frame_seq.sv
// fir_frame_seq
//
// Frame sequencer feeding the 2D FIR line-buffer controller. Accepts an upstream pixel stream
// (valid/ready), counts pixels and lines against a frame geometry latched at start, inserts a
// fixed horizontal blank after every line and appends zero-filled flush lines so the vertically
// delayed filter output covers every input line.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start_i             single-cycle frame start, honoured only while idle
//   cfg_h_size_i        pixels per line, latched on an accepted start (must be >= 2)
//   cfg_v_size_i        input lines per frame, latched on an accepted start (must be >= 1)
//   s_valid_i/s_data_i  upstream pixel stream
//   s_ready_o           pixel accepted this cycle (decoded from state only)
//   lb_ce_o             line-buffer clock enable, one registered pulse per pixel
//   lb_data_o           pixel to the line buffer (0 during flush lines)
//   lb_first_ln_o       issued pixel belongs to frame line 0
//   lb_h_size_o         latched h_size, stable for the whole frame
//   lb_rd_en_o          line-buffer read request (ce on every line except line 0)
//   pixel_cnt_o         registered pixel counter
//   line_cnt_o          registered line counter, flush lines included
//   busy_o              high whenever the sequencer is not idle
//   frame_done_o        one-cycle pulse at frame end
//   cfg_err_o           one-cycle pulse when a start is rejected

module fir_frame_seq #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LINE_CNT    = 12,
    parameter int unsigned HBLANK_CYC  = 2,
    parameter int unsigned FLUSH_LINES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [LINE_CNT-1:0]   cfg_h_size_i,
    input  logic [LINE_CNT-1:0]   cfg_v_size_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  lb_ce_o,
    output logic [DATA_WIDTH-1:0] lb_data_o,
    output logic                  lb_first_ln_o,
    output logic [LINE_CNT-1:0]   lb_h_size_o,
    output logic                  lb_rd_en_o,
    output logic [LINE_CNT-1:0]   pixel_cnt_o,
    output logic [LINE_CNT-1:0]   line_cnt_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  cfg_err_o
);

    // Blank counter only needs to reach HBLANK_CYC-1.
    localparam int unsigned HbW = (HBLANK_CYC > 1) ? $clog2(HBLANK_CYC) : 1;
    localparam logic [HbW-1:0]      HbLast = HbW'(HBLANK_CYC - 1);
    localparam logic [LINE_CNT-1:0] FlushW = LINE_CNT'(FLUSH_LINES);

    typedef enum logic [2:0] {
        StIdle,
        StLine,
        StHblank,
        StFlush,
        StDone
    } state_e;

    state_e                  state_q;
    logic [LINE_CNT-1:0]     h_size_q;
    logic [LINE_CNT-1:0]     v_size_q;
    logic [LINE_CNT-1:0]     pixel_cnt_q;
    logic [LINE_CNT-1:0]     line_cnt_q;
    logic [HbW-1:0]          hb_cnt_q;
    logic                    lb_ce_q;
    logic [DATA_WIDTH-1:0]   lb_data_q;
    logic                    lb_first_ln_q;
    logic                    lb_rd_en_q;
    logic                    frame_done_q;
    logic                    cfg_err_q;

    logic                    issue;
    logic                    last_pix;
    logic                    cfg_ok;
    logic [LINE_CNT-1:0]     h_last;
    logic [LINE_CNT-1:0]     end_lines;

    always_comb begin
        s_ready_o = (state_q == StLine);
        // A pixel is issued on an upstream transfer or on every flush cycle.
        issue     = ((state_q == StLine) && s_valid_i) || (state_q == StFlush);
        h_last    = h_size_q - LINE_CNT'(1);
        last_pix  = (pixel_cnt_q == h_last);
        // Input lines plus flush lines; overflow is excluded by the caller.
        end_lines = v_size_q + FlushW;
        cfg_ok    = (cfg_h_size_i >= LINE_CNT'(2)) && (cfg_v_size_i != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            h_size_q      <= '0;
            v_size_q      <= '0;
            pixel_cnt_q   <= '0;
            line_cnt_q    <= '0;
            hb_cnt_q      <= '0;
            lb_ce_q       <= 1'b0;
            lb_data_q     <= '0;
            lb_first_ln_q <= 1'b0;
            lb_rd_en_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;

            // Line-buffer side strobes follow the issue decision by one cycle.
            lb_ce_q       <= issue;
            lb_first_ln_q <= issue && (line_cnt_q == '0);
            lb_rd_en_q    <= issue && (line_cnt_q != '0);
            if (issue) begin
                lb_data_q <= (state_q == StLine) ? s_data_i : '0;
            end

            // Counter advance is shared by input and flush lines.
            if (issue) begin
                if (last_pix) begin
                    pixel_cnt_q <= '0;
                    line_cnt_q  <= line_cnt_q + LINE_CNT'(1);
                    hb_cnt_q    <= '0;
                end else begin
                    pixel_cnt_q <= pixel_cnt_q + LINE_CNT'(1);
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            h_size_q    <= cfg_h_size_i;
                            v_size_q    <= cfg_v_size_i;
                            pixel_cnt_q <= '0;
                            line_cnt_q  <= '0;
                            state_q     <= StLine;
                        end else begin
                            cfg_err_q   <= 1'b1;
                        end
                    end
                end
                StLine, StFlush: begin
                    if (issue && last_pix) begin
                        state_q <= StHblank;
                    end
                end
                StHblank: begin
                    if (hb_cnt_q == HbLast) begin
                        if (line_cnt_q < v_size_q) begin
                            state_q <= StLine;
                        end else if (line_cnt_q < end_lines) begin
                            state_q <= StFlush;
                        end else begin
                            state_q      <= StDone;
                            frame_done_q <= 1'b1;
                        end
                    end else begin
                        hb_cnt_q <= hb_cnt_q + HbW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign lb_ce_o       = lb_ce_q;
    assign lb_data_o     = lb_data_q;
    assign lb_first_ln_o = lb_first_ln_q;
    assign lb_rd_en_o    = lb_rd_en_q;
    assign lb_h_size_o   = h_size_q;
    assign pixel_cnt_o   = pixel_cnt_q;
    assign line_cnt_o    = line_cnt_q;
    assign busy_o        = (state_q != StIdle);
    assign frame_done_o  = frame_done_q;
    assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_fir_frame_seq.sv
// Scoreboard bench for fir_frame_seq. Stimulus pushes the expected line-buffer pixel sequence
// into a queue; a negedge monitor pops and compares on every lb_ce_o pulse.

module tb_fir_frame_seq;

    localparam int DW = 8;
    localparam int LC = 12;
    localparam int HB = 2;
    localparam int FL = 1;

    localparam int ModeBasic = 0;
    localparam int ModeStall = 1;
    localparam int ModeBusy  = 2;
    localparam int ModeReset = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          first;
        logic          rd;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [LC-1:0] cfg_h;
    logic [LC-1:0] cfg_v;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          lb_ce;
    logic [DW-1:0] lb_data;
    logic          lb_first;
    logic [LC-1:0] lb_h_size;
    logic          lb_rd_en;
    logic [LC-1:0] pixel_cnt;
    logic [LC-1:0] line_cnt;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;

    // Second instance without flush lines for the wide-line test.
    logic          nf_start;
    logic [LC-1:0] nf_h;
    logic [LC-1:0] nf_v;
    logic          nf_valid;
    logic [DW-1:0] nf_data;
    logic          nf_ready;
    logic          nf_ce;
    logic [DW-1:0] nf_lb_data;
    logic          nf_first;
    logic [LC-1:0] nf_h_size;
    logic          nf_rd_en;
    logic [LC-1:0] nf_pixel_cnt;
    logic [LC-1:0] nf_line_cnt;
    logic          nf_busy;
    logic          nf_done;
    logic          nf_cfg_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ce_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   err_cnt = 0;
    bit   done_prev = 1'b0;
    int   nf_ce_cnt = 0;
    int   nf_done_cnt = 0;
    int   nf_done_cyc = 0;
    exp_t exp_q[$];

    fir_frame_seq #(
        .DATA_WIDTH (DW),
        .LINE_CNT   (LC),
        .HBLANK_CYC (HB),
        .FLUSH_LINES(FL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .cfg_h_size_i (cfg_h),
        .cfg_v_size_i (cfg_v),
        .s_valid_i    (s_valid),
        .s_data_i     (s_data),
        .s_ready_o    (s_ready),
        .lb_ce_o      (lb_ce),
        .lb_data_o    (lb_data),
        .lb_first_ln_o(lb_first),
        .lb_h_size_o  (lb_h_size),
        .lb_rd_en_o   (lb_rd_en),
        .pixel_cnt_o  (pixel_cnt),
        .line_cnt_o   (line_cnt),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .cfg_err_o    (cfg_err)
    );

    fir_frame_seq #(
        .DATA_WIDTH (DW),
        .LINE_CNT   (LC),
        .HBLANK_CYC (HB),
        .FLUSH_LINES(0)
    ) dut_nf (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (nf_start),
        .cfg_h_size_i (nf_h),
        .cfg_v_size_i (nf_v),
        .s_valid_i    (nf_valid),
        .s_data_i     (nf_data),
        .s_ready_o    (nf_ready),
        .lb_ce_o      (nf_ce),
        .lb_data_o    (nf_lb_data),
        .lb_first_ln_o(nf_first),
        .lb_h_size_o  (nf_h_size),
        .lb_rd_en_o   (nf_rd_en),
        .pixel_cnt_o  (nf_pixel_cnt),
        .line_cnt_o   (nf_line_cnt),
        .busy_o       (nf_busy),
        .frame_done_o (nf_done),
        .cfg_err_o    (nf_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (lb_ce) begin
            ce_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ce_unexpected: got ce with data %0h, required no pixel", lb_data);
            end else begin
                e = exp_q.pop_front();
                if ({lb_data, lb_first, lb_rd_en} !== {e.data, e.first, e.rd}) begin
                    errors++;
                    $display("FAIL ce_pixel: got data=%0h first=%0b rd=%0b, required data=%0h first=%0b rd=%0b",
                             lb_data, lb_first, lb_rd_en, e.data, e.first, e.rd);
                end
            end
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            checks++;
            if (done_prev) begin
                errors++;
                $display("FAIL done_width: got frame_done high 2 cycles, required 1");
            end
        end
        done_prev = frame_done;
        if (cfg_err) err_cnt++;
        if (nf_ce) nf_ce_cnt++;
        if (nf_done) begin
            nf_done_cnt++;
            nf_done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int l, input int p);
        return DW'((l + 1) * 16 + p + 1);
    endfunction

    function automatic logic [50:0] all_outs();
        return {s_ready, lb_ce, lb_data, lb_first, lb_rd_en, lb_h_size, pixel_cnt, line_cnt,
                busy, frame_done, cfg_err};
    endfunction

    // Offer one pixel and return after the clock edge that accepts it.
    task automatic send(input logic [DW-1:0] d, output int t);
        int  g;
        bit  ok;
        s_valid = 1'b1;
        s_data  = d;
        g  = 0;
        ok = 1'b0;
        t  = -1;
        while (!ok && g < 50) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                t  = cyc;
            end
            g++;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int h, input int v, input int mode);
        int ce0, done0, t, t_first, g;
        ce0   = ce_cnt;
        done0 = done_cnt;
        t_first = 0;
        for (int l = 0; l < v + FL; l++) begin
            for (int p = 0; p < h; p++) begin
                exp_q.push_back('{data: (l < v) ? pix(l, p) : '0, first: (l == 0), rd: (l != 0)});
            end
        end
        check("busy_before_start", 64'(busy), 64'd0);
        cfg_h   = LC'(h);
        cfg_v   = LC'(v);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("h_size_latched", 64'(lb_h_size), 64'(h));
        for (int l = 0; l < v; l++) begin
            for (int p = 0; p < h; p++) begin
                if (mode == ModeStall && l == 1 && p == 2) begin
                    s_valid = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        @(posedge clk);
                        #1;
                        check("stall_ce_low", 64'(lb_ce), 64'd0);
                        check("stall_counters", {32'(line_cnt), 32'(pixel_cnt)}, {32'd1, 32'd2});
                    end
                end
                if (mode == ModeBusy && l == 1 && p == 1) begin
                    start_i = 1'b1;
                    cfg_h   = LC'(7);
                    cfg_v   = LC'(5);
                end
                send(pix(l, p), t);
                if (l == 0 && p == 0) t_first = t;
                if (mode == ModeBusy && l == 1 && p == 1) begin
                    start_i = 1'b0;
                    check("busy_start_h_size", 64'(lb_h_size), 64'(h));
                end
                if (mode == ModeReset && l == 1 && p == 1) begin
                    s_valid = 1'b0;
                    rst_n   = 1'b0;
                    @(posedge clk);
                    #1;
                    check("reset_outputs_zero", 64'(all_outs()), 64'd0);
                    exp_q.delete();
                    rst_n = 1'b1;
                    repeat (10) @(posedge clk);
                    #1;
                    check("reset_no_done", 64'(done_cnt), 64'(done0));
                    check("reset_idle", 64'(busy), 64'd0);
                    return;
                end
            end
        end
        s_valid = 1'b0;
        g = 0;
        while (done_cnt == done0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("frame_done_count", 64'(done_cnt - done0), 64'd1);
        // First transfer observed in the cycle before its edge; frame_done observed in the
        // DONE cycle: one line = h + HB cycles, plus the stall gap.
        check("frame_done_timing", 64'(done_cyc - t_first),
              64'((v + FL) * (h + HB) + ((mode == ModeStall) ? 5 : 0)));
        check("ce_pulse_count", 64'(ce_cnt - ce0), 64'(h * (v + FL)));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic bad_start(input int h, input int v);
        int e0;
        e0 = err_cnt;
        cfg_h   = LC'(h);
        cfg_v   = LC'(v);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("cfg_err_pulse", {32'(cfg_err), 32'(busy)}, {32'd1, 32'd0});
        @(posedge clk);
        #1;
        check("cfg_err_width", {32'(cfg_err), 32'(busy)}, {32'd0, 32'd0});
        check("cfg_err_count", 64'(err_cnt - e0), 64'd1);
    endtask

    initial begin
        int ce0, g, t0;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        cfg_h    = '0;
        cfg_v    = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        nf_start = 1'b0;
        nf_h     = '0;
        nf_v     = '0;
        nf_valid = 1'b0;
        nf_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(all_outs()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame(4, 3, ModeBasic);
        run_frame(4, 3, ModeStall);

        ce0 = ce_cnt;
        bad_start(1, 3);
        bad_start(4, 0);
        repeat (4) @(posedge clk);
        #1;
        check("cfg_err_no_ce", 64'(ce_cnt - ce0), 64'd0);

        run_frame(4, 3, ModeBusy);
        run_frame(4, 3, ModeReset);
        run_frame(2, 1, ModeBasic);

        // Maximum line width on the no-flush instance.
        nf_h     = LC'(4095);
        nf_v     = LC'(1);
        nf_start = 1'b1;
        @(posedge clk);
        #1;
        nf_start = 1'b0;
        nf_valid = 1'b1;
        nf_data  = 8'h5a;
        g = 0;
        @(negedge clk);
        while (!nf_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("nf_ready", 64'(nf_ready), 64'd1);
        t0 = cyc;
        for (int i = 0; i < 4095; i++) begin
            @(posedge clk);
            #1;
            if (i == 4093) check("nf_pixel_4094", 64'(nf_pixel_cnt), 64'd4094);
        end
        nf_valid = 1'b0;
        check("nf_wrap", {32'(nf_line_cnt), 32'(nf_pixel_cnt)}, {32'd1, 32'd0});
        g = 0;
        while (nf_done_cnt == 0 && g < 50) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("nf_done_count", 64'(nf_done_cnt), 64'd1);
        check("nf_done_timing", 64'(nf_done_cyc - t0), 64'(4095 + HB));
        check("nf_ce_count", 64'(nf_ce_cnt), 64'd4095);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
